// File: rtl/core_pkg.sv
// Fetch-path constants and the FIFO entry layout shared by the PC, PC+4 and IF/ID stages.
// No logic of its own.
package core_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_RESET = 32'h0;
    localparam logic [PC_W-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of DEPTH entries; head is read combinationally, writes land one edge later.
// No internal backpressure: the caller guarantees push never hits a full queue.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Clear wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/if_id_buffer.sv
// Pairs each sync-ROM word with its PC, queues it and hands it to decode; 2 cycles request-to-decode.
// if_stall is a registered credit (queued + in-flight >= DEPTH); flush drops everything in flight.
module if_id_buffer
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    input  logic [PC_W-1:0]     if_pc,
    input  logic [INSTR_W-1:0]  rom_instr,
    output logic                if_stall,
    input  logic                flush,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [PC_W-1:0]     id_pc,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [PC_W-1:0]     id_pc_plus4
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic              inflight_v;
    logic [PC_W-1:0]   inflight_pc;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              accept;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      rd_entry;

    // Only registered state feeds the credit, so id_ready/flush never reach the PC enable.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_v};
    assign if_stall  = (occupancy >= DEPTH_C);

    assign accept = if_req_valid && !if_stall && !flush;
    assign push   = inflight_v && !flush;
    assign pop    = id_valid && id_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_v  <= 1'b0;
            inflight_pc <= PC_RESET;
        end else begin
            inflight_v <= accept;
            if (accept) begin
                inflight_pc <= if_pc;
            end
        end
    end

    assign wr_entry.pc    = inflight_pc;
    assign wr_entry.instr = rom_instr;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (count)
    );

    assign id_valid    = (count != '0);
    assign id_pc       = rd_entry.pc;
    assign id_instr    = rd_entry.instr;
    assign id_pc_plus4 = pc_next(rd_entry.pc);
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, streaming, back-pressure, flush/redirect, PC wrap.
module tb_if_id_buffer;
    localparam int DEPTH = 4;
    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic [31:0] rom_instr = 32'h0;
    logic        if_stall;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;

    int checks = 0;
    int errors = 0;
    logic [31:0] p;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_pc        (if_pc),
        .rom_instr    (rom_instr),
        .if_stall     (if_stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_pc_plus4  (id_pc_plus4)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: word for the address presented at the previous edge.
    always @(posedge clk) rom_instr <= if_pc ^ K;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic rdy, input logic fl);
        if_req_valid = req;
        if_pc        = pc;
        id_ready     = rdy;
        flush        = fl;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle;
        next_cycle;
        rst = 1'b1;
    endtask

    // A push into a full queue would mean the credit logic let one too many requests through.
    always @(negedge clk) begin
        if (rst) begin
            check("no_overflow", 32'(dut.u_fifo.push && (dut.u_fifo.count == 3'(DEPTH))), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_vld",   32'(id_valid), 32'h0);
        check("rst_pc",    id_pc,         32'h0);
        check("rst_instr", id_instr,      32'h0);
        check("rst_pc4",   id_pc_plus4,   32'h4);
        check("rst_stall", 32'(if_stall), 32'h0);
        next_cycle;
        rst = 1'b1;

        // Streaming at one per cycle; count sits at 1 with simultaneous push/pop, pointers wrap.
        for (int n = 0; n < 27; n++) begin
            drive(n < 24, (n < 24) ? 32'(4 * n) : 32'h0, 1'b1, 1'b0);
            @(negedge clk);
            check("stream_stall", 32'(if_stall), 32'h0);
            if (n >= 2 && n < 26) begin
                check("stream_vld",   32'(id_valid), 32'h1);
                check("stream_pc",    id_pc,         32'(4 * (n - 2)));
                check("stream_instr", id_instr,      32'(4 * (n - 2)) ^ K);
                check("stream_pc4",   id_pc_plus4,   32'(4 * (n - 1)));
            end else begin
                check("stream_vld", 32'(id_valid), 32'h0);
            end
            next_cycle;
        end

        // Back-pressure: decode stalled for 8 cycles, PC stage holds while if_stall.
        do_reset;
        p = 32'h0;
        for (int k = 0; k < 14; k++) begin
            drive(1'b1, p, k >= 8, 1'b0);
            @(negedge clk);
            check("bp_stall", 32'(if_stall), 32'(k >= 4 && k <= 8));
            check("bp_vld",   32'(id_valid), 32'(k >= 2));
            if (k >= 2) begin
                check("bp_pc",    id_pc,    (k < 8) ? 32'h0 : 32'(4 * (k - 8)));
                check("bp_instr", id_instr, ((k < 8) ? 32'h0 : 32'(4 * (k - 8))) ^ K);
            end
            if (!if_stall) p = p + 32'd4;
            next_cycle;
        end

        // Reset mid-operation with two entries queued.
        do_reset;
        drive(1'b1, 32'h40, 1'b0, 1'b0); next_cycle;
        drive(1'b1, 32'h44, 1'b0, 1'b0); next_cycle;
        drive(1'b0, 32'h0,  1'b0, 1'b0); next_cycle;
        @(negedge clk);
        check("pre_rst_vld", 32'(id_valid), 32'h1);
        check("pre_rst_pc",  id_pc,         32'h40);
        rst = 1'b0;
        #1;
        check("mid_rst_vld",   32'(id_valid), 32'h0);
        check("mid_rst_pc",    id_pc,         32'h0);
        check("mid_rst_instr", id_instr,      32'h0);
        check("mid_rst_pc4",   id_pc_plus4,   32'h4);
        check("mid_rst_stall", 32'(if_stall), 32'h0);
        do_reset;

        // Flush with three queued and one in flight, redirect to 0x100.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
            next_cycle;
        end
        drive(1'b1, 32'h210, 1'b0, 1'b1);
        @(negedge clk);
        check("fl_stall_before", 32'(if_stall), 32'h1);
        check("fl_head_before",  id_pc,         32'h200);
        next_cycle;
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_stall_after", 32'(if_stall), 32'h0);
        check("fl_vld_r0",      32'(id_valid), 32'h0);
        next_cycle;
        drive(1'b1, 32'h104, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_vld_r1", 32'(id_valid), 32'h0);
        next_cycle;
        drive(1'b1, 32'h108, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_vld_r2",   32'(id_valid), 32'h1);
        check("fl_pc_r2",    id_pc,         32'h100);
        check("fl_instr_r2", id_instr,      32'h100 ^ K);
        next_cycle;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("fl_pc_r3", id_pc, 32'h104);
        next_cycle;
        @(negedge clk);
        check("fl_pc_r4", id_pc, 32'h108);
        next_cycle;
        @(negedge clk);
        check("fl_vld_r5", 32'(id_valid), 32'h0);

        // PC+4 wraps at the top of the address space.
        do_reset;
        drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0); next_cycle;
        drive(1'b0, 32'h0, 1'b1, 1'b0); next_cycle;
        @(negedge clk);
        check("wrap_vld",   32'(id_valid), 32'h1);
        check("wrap_pc",    id_pc,         32'hFFFF_FFFC);
        check("wrap_instr", id_instr,      32'hFFFF_FFFC ^ K);
        check("wrap_pc4",   id_pc_plus4,   32'h0000_0000);
        next_cycle;
        @(negedge clk);
        check("wrap_drain", 32'(id_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
